// File: rtl/timer_input_capture.sv
// Timer input-capture channel: synchronises and filters the timer input pin, detects the selected edge,
// divides edge events by 1/2/4/8 and latches the timer counter with capture/overcapture flags.
module timer_input_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             aresetn_i,
    input  logic             cce_i,
    input  logic [1:0]       icps_i,
    input  logic             ccp_i,
    input  logic [1:0]       icf_i,
    input  logic             tim_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             flag_clr_i,
    output logic [CNT_W-1:0] ccr_o,
    output logic             cap_o,
    output logic             ccif_o,
    output logic             ccof_o
);

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic             filt_prev_q;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [2:0]       pcnt_q, pcnt_d;
    logic [2:0]       flen_max;
    logic [2:0]       pre_max;
    logic             edge_s;
    logic             capture;
    logic [CNT_W-1:0] ccr_q, ccr_d;
    logic             cap_q;
    logic             ccif_q, ccif_d;
    logic             ccof_q, ccof_d;

    always_comb begin
        case (icf_i)
            2'b00:   flen_max = 3'd0;
            2'b01:   flen_max = 3'd1;
            2'b10:   flen_max = 3'd3;
            default: flen_max = 3'd7;
        endcase
        case (icps_i)
            2'b00:   pre_max = 3'd0;
            2'b01:   pre_max = 3'd1;
            2'b10:   pre_max = 3'd3;
            default: pre_max = 3'd7;
        endcase
    end

    // The filter only adopts the synchronised level after it has differed for N consecutive samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = 3'd0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == flen_max) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 3'd1;
            end
        end
    end

    // The >= compare lets a prescaler reduced mid-count capture on the very next edge.
    always_comb begin
        edge_s  = ccp_i ? (filt_prev_q & ~filt_q) : (~filt_prev_q & filt_q);
        capture = cce_i & edge_s & (pcnt_q >= pre_max);
        pcnt_d  = pcnt_q;
        if (!cce_i) begin
            pcnt_d = 3'd0;
        end else if (edge_s) begin
            pcnt_d = capture ? 3'd0 : pcnt_q + 3'd1;
        end
    end

    always_comb begin
        ccr_d  = ccr_q;
        ccif_d = ccif_q;
        ccof_d = ccof_q;
        if (capture) begin
            ccr_d  = cnt_i;
            ccif_d = 1'b1;
            ccof_d = (ccof_q | ccif_q) & ~flag_clr_i;
        end else if (flag_clr_i) begin
            ccif_d = 1'b0;
            ccof_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            fcnt_q      <= 3'd0;
            pcnt_q      <= 3'd0;
            ccr_q       <= '0;
            cap_q       <= 1'b0;
            ccif_q      <= 1'b0;
            ccof_q      <= 1'b0;
        end else begin
            sync1_q     <= tim_i;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            pcnt_q      <= pcnt_d;
            ccr_q       <= ccr_d;
            cap_q       <= capture;
            ccif_q      <= ccif_d;
            ccof_q      <= ccof_d;
        end
    end

    assign ccr_o  = ccr_q;
    assign cap_o  = cap_q;
    assign ccif_o = ccif_q;
    assign ccof_o = ccof_q;

endmodule

// File: tb/tb_timer_input_capture.sv
// Scoreboard bench for timer_input_capture: a cycle-level reference model predicts captures and flags,
// a monitor compares them against the DUT, and directed scenarios check latency and prescaling.
module tb_timer_input_capture;

    localparam int CNT_W = 16;

    logic             clk_i;
    logic             aresetn_i;
    logic             cce_i;
    logic [1:0]       icps_i;
    logic             ccp_i;
    logic [1:0]       icf_i;
    logic             tim_i;
    logic [CNT_W-1:0] cnt_i;
    logic             flag_clr_i;
    logic [CNT_W-1:0] ccr_o;
    logic             cap_o;
    logic             ccif_o;
    logic             ccof_o;

    typedef struct {
        logic [CNT_W-1:0] ccr;
        bit               ccif;
        bit               ccof;
    } capExp_t;

    capExp_t expQ[$];
    capExp_t expItem;
    capExp_t gotItem;
    bit      pinHist[$];
    bit      filtM, filtPrevM, edgeM, capM, allDiff;
    bit      ccifM, ccofM;
    int      preCount;
    int      filtLen;
    int      assertions = 0;
    int      failures   = 0;
    int      capCount   = 0;
    int      base;
    int      segLeft;

    timer_input_capture #(.CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .aresetn_i  (aresetn_i),
        .cce_i      (cce_i),
        .icps_i     (icps_i),
        .ccp_i      (ccp_i),
        .icf_i      (icf_i),
        .tim_i      (tim_i),
        .cnt_i      (cnt_i),
        .flag_clr_i (flag_clr_i),
        .ccr_o      (ccr_o),
        .cap_o      (cap_o),
        .ccif_o     (ccif_o),
        .ccof_o     (ccof_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        cnt_i = 16'h0100;
        forever begin
            @(negedge clk_i);
            cnt_i = cnt_i + 16'd1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit level, input int cycles);
        tim_i = level;
        repeat (cycles) @(negedge clk_i);
    endtask

    // Counts rising clock edges from the current stimulus until cap_o appears (0 = none within 20);
    // pulseLen > 0 drops tim_i after that many edges.
    task automatic checkLatency(input string name, input int expected, input int pulseLen);
        int got;
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_i);
            #1;
            if (pulseLen > 0 && i == pulseLen) tim_i = 1'b0;
            if (cap_o) begin
                got = i;
                break;
            end
        end
        checkOutput(name, got, expected);
        @(negedge clk_i);
    endtask

    task automatic pulseFlagClear;
        flag_clr_i = 1'b1;
        @(negedge clk_i);
        flag_clr_i = 1'b0;
    endtask

    // Reference model: the pin is sampled each clock; the filtered level flips once the last N
    // synchronised samples (two clocks old) all disagree with it; a level change is an edge one clock later.
    initial begin
        forever begin
            @(posedge clk_i);
            if (!aresetn_i) begin
                pinHist.delete();
                for (int i = 0; i < 12; i++) pinHist.push_front(1'b0);
                filtM = 0; filtPrevM = 0; preCount = 0;
                ccifM = 0; ccofM = 0;
                expQ.delete();
            end else begin
                edgeM = ccp_i ? (filtPrevM && !filtM) : (!filtPrevM && filtM);
                capM  = 0;
                if (!cce_i) begin
                    preCount = 0;
                end else if (edgeM) begin
                    preCount++;
                    if (preCount >= (1 << icps_i)) begin
                        capM = 1;
                        preCount = 0;
                    end
                end
                if (capM) begin
                    ccofM        = (ccofM || ccifM) && !flag_clr_i;
                    ccifM        = 1;
                    expItem.ccr  = cnt_i;
                    expItem.ccif = 1;
                    expItem.ccof = ccofM;
                    expQ.push_back(expItem);
                end else if (flag_clr_i) begin
                    ccifM = 0;
                    ccofM = 0;
                end
                pinHist.push_front(tim_i);
                void'(pinHist.pop_back());
                filtLen = 1 << icf_i;
                allDiff = 1;
                for (int i = 2; i <= filtLen + 1; i++)
                    if (pinHist[i] == filtM) allDiff = 0;
                filtPrevM = filtM;
                if (allDiff) filtM = !filtM;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (aresetn_i) begin
                if (cap_o) begin
                    capCount++;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected cap_o", 1, 0);
                    end else begin
                        gotItem = expQ.pop_front();
                        checkOutput("ccr_o on capture", int'(ccr_o), int'(gotItem.ccr));
                    end
                end else if (expQ.size() != 0) begin
                    gotItem = expQ.pop_front();
                    checkOutput("missing cap_o", 0, 1);
                end
                checkOutput("ccif_o tracking", int'(ccif_o), int'(ccifM));
                checkOutput("ccof_o tracking", int'(ccof_o), int'(ccofM));
            end
        end
    end

    initial begin
        aresetn_i = 1'b0; cce_i = 1'b1; icps_i = 2'b00; ccp_i = 1'b0;
        icf_i = 2'b00; tim_i = 1'b0; flag_clr_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 aresetn_i = 1'b1;
        @(negedge clk_i);

        tim_i = 1'b1;
        checkLatency("rise latency N=1", 4, 0);
        checkOutput("ccif after first capture", int'(ccif_o), 1);
        checkOutput("ccof after first capture", int'(ccof_o), 0);
        applyStimulus(0, 6);
        icf_i = 2'b11;
        applyStimulus(0, 2);
        tim_i = 1'b1;
        checkLatency("rise latency N=8", 11, 0);
        applyStimulus(0, 12);
        pulseFlagClear();

        icf_i = 2'b10;
        tim_i = 1'b1;
        checkLatency("filter rejects 3-cycle pulse", 0, 3);
        applyStimulus(0, 4);
        tim_i = 1'b1;
        checkLatency("filter passes 4-cycle pulse", 7, 4);
        applyStimulus(0, 10);

        icf_i = 2'b00;
        cce_i = 1'b0;
        applyStimulus(1, 8);
        cce_i = 1'b1; ccp_i = 1'b1; icps_i = 2'b10;
        base = capCount;
        repeat (10) begin
            applyStimulus(0, 4);
            applyStimulus(1, 4);
        end
        applyStimulus(1, 4);
        checkOutput("div4 falling captures over 10 edges", capCount - base, 2);
        base = capCount;
        repeat (2) begin
            applyStimulus(0, 4);
            applyStimulus(1, 4);
        end
        applyStimulus(1, 4);
        checkOutput("div4 count resumes at 2", capCount - base, 1);

        applyStimulus(0, 6);
        ccp_i = 1'b0; icps_i = 2'b00;
        pulseFlagClear();
        repeat (2) begin
            applyStimulus(1, 5);
            applyStimulus(0, 5);
        end
        checkOutput("ccof after two uncleared captures", int'(ccof_o), 1);
        pulseFlagClear();
        checkOutput("ccif after clear", int'(ccif_o), 0);
        checkOutput("ccof after clear", int'(ccof_o), 0);
        applyStimulus(1, 5);
        applyStimulus(0, 5);
        checkOutput("ccif after post-clear capture", int'(ccif_o), 1);
        checkOutput("ccof after post-clear capture", int'(ccof_o), 0);
        tim_i = 1'b1;
        repeat (3) @(negedge clk_i);
        pulseFlagClear();
        checkOutput("ccif with clear coincident", int'(ccif_o), 1);
        checkOutput("ccof with clear coincident", int'(ccof_o), 0);
        applyStimulus(1, 2);
        applyStimulus(0, 5);

        icps_i = 2'b01;
        cce_i = 1'b0;
        base = capCount;
        repeat (5) begin
            applyStimulus(1, 5);
            applyStimulus(0, 5);
        end
        checkOutput("no captures while disabled", capCount - base, 0);
        cce_i = 1'b1;
        base = capCount;
        applyStimulus(1, 5);
        applyStimulus(0, 5);
        checkOutput("re-enable first edge not captured", capCount - base, 0);
        applyStimulus(1, 5);
        applyStimulus(0, 5);
        checkOutput("re-enable second edge captured", capCount - base, 1);
        icps_i = 2'b11;
        base = capCount;
        repeat (5) begin
            applyStimulus(1, 5);
            applyStimulus(0, 5);
        end
        icps_i = 2'b01;
        applyStimulus(1, 5);
        applyStimulus(0, 5);
        checkOutput("prescale reduced mid-count captures", capCount - base, 1);

        icf_i = 2'b11; icps_i = 2'b10;
        repeat (2) begin
            applyStimulus(1, 10);
            applyStimulus(0, 12);
        end
        applyStimulus(1, 4);
        #1 aresetn_i = 1'b0;
        #1;
        checkOutput("ccr_o in reset", int'(ccr_o), 0);
        checkOutput("cap_o in reset", int'(cap_o), 0);
        checkOutput("ccif_o in reset", int'(ccif_o), 0);
        checkOutput("ccof_o in reset", int'(ccof_o), 0);
        icf_i = 2'b00; icps_i = 2'b00;
        @(negedge clk_i);
        @(negedge clk_i);
        #2 aresetn_i = 1'b1;
        checkLatency("rise latency after reset", 4, 0);
        checkOutput("first capture after reset not overcapture", int'(ccof_o), 0);
        applyStimulus(0, 10);

        for (int phase = 0; phase < 6; phase++) begin
            flag_clr_i = 1'b0;
            applyStimulus(tim_i, 20);
            icf_i   = 2'($urandom_range(0, 3));
            segLeft = 0;
            for (int c = 0; c < 150; c++) begin
                if (segLeft == 0) begin
                    tim_i   = 1'($urandom_range(0, 1));
                    segLeft = $urandom_range(1, 12);
                end
                segLeft--;
                flag_clr_i = ($urandom_range(0, 9) == 0);
                cce_i      = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 29) == 0) icps_i = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 29) == 0) ccp_i = 1'($urandom_range(0, 1));
                @(negedge clk_i);
            end
        end
        flag_clr_i = 1'b0;
        cce_i = 1'b1;
        applyStimulus(tim_i, 25);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/timer_input_capture.md
# timer_input_capture

Input-capture channel for the general-purpose timer: the receive-side counterpart of the output prescaler/divider. It synchronises and filters an external timer input pin, detects the selected edge, and divides the edge events by 1/2/4/8. On each qualifying event it latches the running timer counter into a capture register and raises capture and overcapture flags for the register/interrupt logic.

## Interface
- `CNT_W`, default 16: width of the timer counter and capture register.

- `clk_i` in 1: timer kernel clock.
- `aresetn_i` in 1: reset, asynchronous and active-low.
- `cce_i` in 1: capture channel enable.
- `icps_i` in 2: input-capture prescaler; 00 = every edge, 01 = every 2nd, 10 = every 4th, 11 = every 8th.
- `ccp_i` in 1: edge polarity; 0 = rising, 1 = falling.
- `icf_i` in 2: filter length N; 00 = 1, 01 = 2, 10 = 4, 11 = 8 samples.
- `tim_i` in 1: raw asynchronous timer input pin.
- `cnt_i` in CNT_W: current timer counter value.
- `flag_clr_i` in 1: single-cycle clear of `ccif_o` and `ccof_o`.
- `ccr_o` out CNT_W: capture register.
- `cap_o` out 1: one-cycle pulse on each capture.
- `ccif_o` out 1: capture flag, sticky.
- `ccof_o` out 1: overcapture flag, sticky.

## Operation
- **Reset values:** all flops are 0, including the synchroniser, filtered level, filter counter, prescaler counter, `ccr_o`, `cap_o`, `ccif_o` and `ccof_o`.
  - Consequence: a `tim_i` that is high out of reset produces a rising edge.
- **Synchroniser:** 2-flop chain on `tim_i`, giving `sync`.
- **Filter:**
  - Registered level `filt` and a 3-bit counter `fcnt`.
  - If `sync == filt`: `fcnt` <= 0.
  - Else if `fcnt == N-1`: `filt` <= `sync` and `fcnt` <= 0.
  - Else: `fcnt` <= `fcnt` + 1.
  - With N=1, `filt` follows `sync` one cycle later.
  - Pulses shorter than N cycles at `sync` are rejected.
- **Edge detect:** `filt_d` is the previous `filt`.
  - `edge = ccp_i ? (filt_d & ~filt) : (~filt_d & filt)`.
  - Combinational, single cycle.
- **Prescaler:** 3-bit `pcnt`; D = 1, 2, 4 or 8 from `icps_i`.
  - `cce_i` = 0: `pcnt` <= 0 and no capture occurs. The synchroniser and filter keep running.
  - `cce_i` = 1 and `edge`:
    - If `pcnt >= D-1`: capture and `pcnt` <= 0.
    - Else: `pcnt` <= `pcnt` + 1.
  - The `>=` compare handles `icps_i` reduced mid-count: the next edge captures and no wrap is needed.
  - Changes to `icps_i` or `ccp_i` take effect on the next edge evaluation. No other reset of `pcnt`.
- **Capture (registered, same edge as the decision):**
  - `ccr_o` <= `cnt_i`.
  - `cap_o` <= 1. It is 0 in every other cycle.
  - `ccif_o` <= 1.
  - `ccof_o` <= `ccof_o` | `ccif_o`, i.e. set if the previous capture was not yet cleared.
- **Flag clear** (`flag_clr_i` = 1):
  - Without a capture in the same cycle: `ccif_o` <= 0 and `ccof_o` <= 0.
  - Simultaneous with a capture: the capture wins on `ccif_o` (1), and `ccof_o` <= 0.
- **Reset mid-operation:** asynchronous return to the reset values listed above. The first capture after reset is never an overcapture.

## Timing
- Let `tim_i` change before clock edge k, so it is stable at edge k.
  - `sync` is updated at edge k+1.
  - `filt` is updated at edge k+1+N.
  - The capture registers update at edge k+2+N.
  - Latency is 3 cycles with N=1 and 10 cycles with N=8.
- `ccr_o` holds the `cnt_i` value present in the cycle before the capture edge, i.e. the cycle in which `edge` = 1.
- **Capture rate:** at most one capture per 2N cycles of input activity.
- `cce_i` is sampled in the same cycle as `edge`.
  - If `cce_i` = 0 in that cycle, the edge is dropped and not counted.
- `ccif_o` and `ccof_o` are only ever cleared by `flag_clr_i` or by reset.

## Test plan
1. **Rising capture, no filter or prescale.**
   - Setup: `icf_i`=00, `icps_i`=00, `ccp_i`=0, `cnt_i` incrementing from 0x0100 each cycle, `tim_i` 0->1 stable at edge k.
   - Required: `cap_o` high exactly one cycle after edge k+3; `ccr_o` = `cnt_i` of the cycle before edge k+3; `ccif_o`=1, `ccof_o`=0.
2. **Filter.**
   - Setup: `icf_i`=10 (N=4).
   - Required: a 3-cycle `tim_i` high pulse produces no `cap_o`. A 4-cycle pulse produces a capture at edge k+6.
3. **Prescale by 4, falling polarity.**
   - Setup: `ccp_i`=1, `icps_i`=10, 10 falling edges.
   - Required: captures on falling edges 4 and 8 only; `pcnt`=2 at the end.
4. **Overcapture.**
   - Sequence: two captures with no clear -> `ccof_o`=1. Assert `flag_clr_i` -> both flags 0. Next capture -> `ccif_o`=1, `ccof_o`=0.
   - Also: `flag_clr_i` coincident with a capture -> `ccif_o`=1, `ccof_o`=0.
5. **Enable and prescale change.**
   - `cce_i`=0 during 5 edges: no captures; re-enable and `pcnt` starts from 0.
   - With `icps_i`=11 and `pcnt`=5, switch to 01: the next edge captures.
6. **Reset mid-filter and mid-count.**
   - Deassert `aresetn_i` while `fcnt`>0 and `pcnt`>0.
   - Required: all outputs 0 immediately (asynchronously). After release, `tim_i` held high yields the first rising capture at the nominal latency.
